// File: rtl/display_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | display_pkg: glyphs, colours and state encodings for the result  |
// | display. Rev 1.0                                                 |
// +------------------------------------------------------------------+
package display_pkg;

  typedef enum logic [1:0] {
    GS_FIGHT  = 2'b00,
    GS_P1_WIN = 2'b01,
    GS_P2_WIN = 2'b10,
    GS_DRAW   = 2'b11
  } game_state_e;

  typedef enum logic [1:0] {
    ST_FIGHT = 2'd0,
    ST_FLASH = 2'd1,
    ST_SHOW  = 2'd2
  } disp_state_e;

  // Active-low segments, bit6=g ... bit0=a
  localparam logic [6:0] GLYPH_W     = 7'h41;
  localparam logic [6:0] GLYPH_I     = 7'h79;
  localparam logic [6:0] GLYPH_N     = 7'h48;
  localparam logic [6:0] GLYPH_L     = 7'h47;
  localparam logic [6:0] GLYPH_O     = 7'h40;
  localparam logic [6:0] GLYPH_S     = 7'h12;
  localparam logic [6:0] GLYPH_E     = 7'h06;
  localparam logic [6:0] GLYPH_DASH  = 7'h3F;
  localparam logic [6:0] GLYPH_BLANK = 7'h7F;

  localparam logic [15:0] COLOUR_GREEN = 16'h07E0;
  localparam logic [15:0] COLOUR_RED   = 16'hF800;
  localparam logic [15:0] COLOUR_WHITE = 16'hFFFF;
  localparam logic [15:0] COLOUR_BLACK = 16'h0000;

  // pos counts from the leftmost digit; only the first four carry text
  function automatic logic [6:0] digit_glyph(game_state_e gs, logic [7:0] pos);
    logic [6:0] g;
    g = GLYPH_BLANK;
    if (pos < 8'd4) begin
      case (gs)
        GS_FIGHT: g = GLYPH_DASH;
        GS_P1_WIN: begin
          case (pos[1:0])
            2'd0:    g = GLYPH_W;
            2'd1:    g = GLYPH_I;
            2'd2:    g = GLYPH_N;
            default: g = GLYPH_BLANK;
          endcase
        end
        GS_P2_WIN: begin
          case (pos[1:0])
            2'd0:    g = GLYPH_L;
            2'd1:    g = GLYPH_O;
            2'd2:    g = GLYPH_S;
            default: g = GLYPH_E;
          endcase
        end
        default: g = GLYPH_O;
      endcase
    end
    return g;
  endfunction

  function automatic logic [15:0] banner_colour(game_state_e gs);
    logic [15:0] c;
    case (gs)
      GS_P1_WIN: c = COLOUR_GREEN;
      GS_P2_WIN: c = COLOUR_RED;
      GS_DRAW:   c = COLOUR_WHITE;
      default:   c = COLOUR_BLACK;
    endcase
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tick_gen.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tick_gen: one-cycle pulse every DIV cycles, restartable by clr.  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tick_gen #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = (cnt_q == LAST);
    cnt_d = cnt_q + 1'b1;
    if (clr || tick) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule
`default_nettype wire

// File: rtl/result_display_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | result_display_ctrl: 7-segment scan and OLED banner driven by    |
// | the game state, with fight blink and result flash. Rev 1.0       |
// +------------------------------------------------------------------+
module result_display_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 100_000,
  parameter int BLINK_DIV    = 25_000_000,
  parameter int FLASH_BLINKS = 3,
  parameter int OLED_W       = 96,
  parameter int BANNER_Y0    = 22,
  parameter int BANNER_H     = 20
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [12:0]           pixel_index,
  input  logic [1:0]            game_state,
  output logic [6:0]            seg,
  output logic [NUM_DIGITS-1:0] an,
  output logic [15:0]           oled_colour,
  output logic                  result_valid
);

  import display_pkg::*;

  localparam int                IDX_W     = $clog2(NUM_DIGITS);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam int                HALF_W    = $clog2(2 * FLASH_BLINKS + 1);
  localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(2 * FLASH_BLINKS - 1);
  localparam logic [12:0]       BANNER_LO = 13'(BANNER_Y0 * OLED_W);
  localparam logic [12:0]       BANNER_HI = 13'((BANNER_Y0 + BANNER_H) * OLED_W);

  game_state_e       gs_q, gs_d, gs_prev_q, gs_prev_d, res_q, res_d;
  disp_state_e       state_q, state_d;
  logic              restart, trans;
  logic              scan_tick, blink_tick;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [HALF_W-1:0] half_q, half_d;
  logic              phase_q, phase_d;
  logic              visible, in_banner;
  game_state_e       shown_gs;
  logic [6:0]        seg_q, seg_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [15:0]       oled_q, oled_d;

  tick_gen #(.DIV(SCAN_DIV)) u_scan_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (1'b0),
    .tick (scan_tick)
  );

  tick_gen #(.DIV(BLINK_DIV)) u_blink_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (trans),
    .tick (blink_tick)
  );

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_FIGHT;
    else     state_q <= state_d;
  end

  // FSM: next state. A new result always (re)starts the flash, even mid-flash.
  always_comb begin
    state_d = state_q;
    restart = 1'b0;
    if (gs_q == GS_FIGHT) begin
      state_d = ST_FIGHT;
    end else if ((gs_q != gs_prev_q) || (state_q == ST_FIGHT)) begin
      state_d = ST_FLASH;
      restart = 1'b1;
    end else if ((state_q == ST_FLASH) && blink_tick && (half_q == HALF_LAST)) begin
      state_d = ST_SHOW;
    end
    trans = restart || (state_d != state_q);
  end

  // FSM: outputs
  always_comb begin
    result_valid = (state_q == ST_SHOW);
    visible      = (state_q == ST_SHOW) || phase_q;
    shown_gs     = (state_q == ST_FIGHT) ? GS_FIGHT : res_q;
  end

  always_comb begin
    gs_d      = game_state_e'(game_state);
    gs_prev_d = gs_q;
    res_d     = restart ? gs_q : res_q;

    idx_d = idx_q;
    if (scan_tick) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;

    half_d  = half_q;
    phase_d = phase_q;
    if (trans) begin
      half_d  = '0;
      phase_d = 1'b1;
    end else if (blink_tick) begin
      phase_d = ~phase_q;
      if (state_q == ST_FLASH) half_d = half_q + 1'b1;
    end

    // Index 0 is the leftmost digit, which sits on the top anode bit
    seg_d = visible ? digit_glyph(shown_gs, 8'(idx_d)) : GLYPH_BLANK;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      an_d[i] = (i != (NUM_DIGITS - 1 - int'(idx_d)));
    end

    in_banner = (pixel_index >= BANNER_LO) && (pixel_index < BANNER_HI);
    oled_d    = (in_banner && visible && (state_q != ST_FIGHT)) ?
                banner_colour(res_q) : COLOUR_BLACK;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gs_q      <= GS_FIGHT;
      gs_prev_q <= GS_FIGHT;
      res_q     <= GS_FIGHT;
      idx_q     <= '0;
      half_q    <= '0;
      phase_q   <= 1'b1;
      seg_q     <= GLYPH_BLANK;
      an_q      <= '1;
      oled_q    <= COLOUR_BLACK;
    end else begin
      gs_q      <= gs_d;
      gs_prev_q <= gs_prev_d;
      res_q     <= res_d;
      idx_q     <= idx_d;
      half_q    <= half_d;
      phase_q   <= phase_d;
      seg_q     <= seg_d;
      an_q      <= an_d;
      oled_q    <= oled_d;
    end
  end

  assign seg         = seg_q;
  assign an          = an_q;
  assign oled_colour = oled_q;

endmodule
`default_nettype wire
